// File: rtl/stage_mem_pt2_pkg.sv
// rtl/stage_mem_pt2_pkg.sv - shared load types, payload field positions and FSM states for mem stage 2
package stage_mem_pt2_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LBU = 3'd1,
    LD_LH  = 3'd2,
    LD_LHU = 3'd3,
    LD_LW  = 3'd4
  } ld_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BUF,
    ST_DRAIN
  } mem2_state_e;

  // info_data / info_cp0 layout: {wdata, waddr[4:0], wen, valid}
  localparam int DATA_VALID_BIT = 0;
  localparam int DATA_WEN_BIT   = 1;
  localparam int DATA_WADDR_LO  = 2;
  localparam int DATA_WDATA_LO  = 7;

  // load_info layout: {is_load, ld_type[2:0], addr_lo[1:0]}
  localparam int LOAD_IS_LOAD_BIT = 5;
  localparam int LOAD_TYPE_LO     = 2;

  typedef struct packed {
    logic self_stall;
    logic up_stall;
  } stall_bus_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/halfword of a load word and sign/zero-extends it
module load_align
  import stage_mem_pt2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        ld_type,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (ld_type_e'(ld_type))
      LD_LB:   result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_LH:   result = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_LHU:  result = {{(DATA_W-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/stage_mem_pt2.sv
// rtl/stage_mem_pt2.sv - second memory stage: latches mem_pt1 payload, waits for load data, aligns it for WB
module stage_mem_pt2
  import stage_mem_pt2_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int LD_TIMEOUT_W = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic [1:0]              stall_mempt1_mempt2,
  input  logic [DATA_W+6:0]       info_data_mem_1,
  input  logic [2*DATA_W+3:0]     info_hilo_mem_1,
  input  logic [DATA_W+6:0]       info_cp0_mem_1,
  input  logic [5:0]              load_info_mem_1,
  input  logic [DATA_W-1:0]       pc_mempt1,
  input  logic                    data_sram_data_ok,
  input  logic [DATA_W-1:0]       data_sram_rdata,
  output logic [DATA_W+6:0]       info_data_mem_2,
  output logic [2*DATA_W+3:0]     info_hilo_mem_2,
  output logic [DATA_W+6:0]       info_cp0_mem_2,
  output logic [DATA_W-1:0]       pc_mempt2,
  output logic                    stall_req_mempt2,
  output logic                    fwd_en,
  output logic [4:0]              fwd_addr,
  output logic [DATA_W-1:0]       fwd_data,
  output logic                    fwd_pending,
  output logic [LD_TIMEOUT_W-1:0] ld_wait_cnt
);

  stall_bus_t        stall_bus;
  mem2_state_e       state, state_n;
  logic [DATA_W+6:0] data_q;
  logic [5:0]        load_q;
  logic [DATA_W-1:0] rbuf;
  logic [DATA_W-1:0] align_src;
  logic [DATA_W-1:0] aligned;
  logic              load_fire;
  logic              enter_wait;
  logic              use_rbuf;
  logic              is_load_q;

  assign stall_bus = stall_bus_t'(stall_mempt1_mempt2);

  // a valid load is being captured into the payload at this edge
  assign load_fire = !flush && !stall_bus.self_stall
                   && load_info_mem_1[LOAD_IS_LOAD_BIT] && info_data_mem_1[DATA_VALID_BIT];

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      data_q          <= '0;
      info_hilo_mem_2 <= '0;
      info_cp0_mem_2  <= '0;
      load_q          <= '0;
      pc_mempt2       <= '0;
    end else if (flush || (stall_bus.self_stall && !stall_bus.up_stall)) begin
      data_q          <= '0;
      info_hilo_mem_2 <= '0;
      info_cp0_mem_2  <= '0;
      load_q          <= '0;
      pc_mempt2       <= '0;
    end else if (!stall_bus.self_stall) begin
      data_q          <= info_data_mem_1;
      info_hilo_mem_2 <= info_hilo_mem_1;
      info_cp0_mem_2  <= info_cp0_mem_1;
      load_q          <= load_info_mem_1;
      pc_mempt2       <= pc_mempt1;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state       <= ST_IDLE;
      rbuf        <= '0;
      ld_wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == ST_WAIT && data_sram_data_ok) begin
        rbuf <= data_sram_rdata;
      end
      if (enter_wait) begin
        ld_wait_cnt <= '0;
      end else if (state == ST_WAIT && ld_wait_cnt != {LD_TIMEOUT_W{1'b1}}) begin
        ld_wait_cnt <= ld_wait_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n          = state;
    stall_req_mempt2 = 1'b0;
    fwd_pending      = 1'b0;
    use_rbuf         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_fire) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        fwd_pending      = 1'b1;
        stall_req_mempt2 = !data_sram_data_ok;
        if (data_sram_data_ok) begin
          if (flush)                     state_n = ST_IDLE;
          else if (stall_bus.self_stall) state_n = ST_BUF;
          else if (load_fire)            state_n = ST_WAIT;
          else                           state_n = ST_IDLE;
        end else if (flush) begin
          state_n = ST_DRAIN;
        end
      end
      ST_BUF: begin
        use_rbuf = 1'b1;
        if (flush)                      state_n = ST_IDLE;
        else if (!stall_bus.self_stall) state_n = load_fire ? ST_WAIT : ST_IDLE;
      end
      ST_DRAIN: begin
        // the orphaned response of the flushed load is swallowed here
        stall_req_mempt2 = !data_sram_data_ok;
        if (data_sram_data_ok) state_n = load_fire ? ST_WAIT : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // re-entry from WAIT happens when the response and the next load meet on one edge
  assign enter_wait = (state_n == ST_WAIT) && ((state != ST_WAIT) || data_sram_data_ok);

  assign align_src = use_rbuf ? rbuf : data_sram_rdata;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata   (align_src),
    .ld_type (load_q[LOAD_TYPE_LO +: 3]),
    .addr_lo (load_q[1:0]),
    .result  (aligned)
  );

  assign is_load_q = load_q[LOAD_IS_LOAD_BIT] && data_q[DATA_VALID_BIT];

  always_comb begin
    info_data_mem_2 = data_q;
    if (is_load_q) begin
      info_data_mem_2 = {aligned, data_q[DATA_WDATA_LO-1:0]};
    end
  end

  assign fwd_en   = info_data_mem_2[DATA_WEN_BIT] && info_data_mem_2[DATA_VALID_BIT] && !fwd_pending;
  assign fwd_addr = info_data_mem_2[DATA_WADDR_LO +: 5];
  assign fwd_data = info_data_mem_2[DATA_WDATA_LO +: DATA_W];

endmodule

// File: tb/tb_stage_mem_pt2.sv
// tb/tb_stage_mem_pt2.sv - scoreboard bench for stage_mem_pt2
module tb_stage_mem_pt2;

  typedef struct packed {
    logic [38:0] d;
    logic [67:0] h;
    logic [38:0] c;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [1:0]  stall_force;
  logic [1:0]  stall;
  logic [38:0] info_data_mem_1;
  logic [67:0] info_hilo_mem_1;
  logic [38:0] info_cp0_mem_1;
  logic [5:0]  load_info_mem_1;
  logic [31:0] pc_mempt1;
  logic        data_ok;
  logic [31:0] rdata;
  logic [38:0] info_data_mem_2;
  logic [67:0] info_hilo_mem_2;
  logic [38:0] info_cp0_mem_2;
  logic [31:0] pc_mempt2;
  logic        stall_req;
  logic        fwd_en;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        fwd_pending;
  logic [3:0]  ld_wait_cnt;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // stall controller: a stage request freezes this stage and upstream
  assign stall = stall_force | {2{stall_req}};

  stage_mem_pt2 #(.DATA_W(32), .LD_TIMEOUT_W(4)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .flush               (flush),
    .stall_mempt1_mempt2 (stall),
    .info_data_mem_1     (info_data_mem_1),
    .info_hilo_mem_1     (info_hilo_mem_1),
    .info_cp0_mem_1      (info_cp0_mem_1),
    .load_info_mem_1     (load_info_mem_1),
    .pc_mempt1           (pc_mempt1),
    .data_sram_data_ok   (data_ok),
    .data_sram_rdata     (rdata),
    .info_data_mem_2     (info_data_mem_2),
    .info_hilo_mem_2     (info_hilo_mem_2),
    .info_cp0_mem_2      (info_cp0_mem_2),
    .pc_mempt2           (pc_mempt2),
    .stall_req_mempt2    (stall_req),
    .fwd_en              (fwd_en),
    .fwd_addr            (fwd_addr),
    .fwd_data            (fwd_data),
    .fwd_pending         (fwd_pending),
    .ld_wait_cnt         (ld_wait_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    info_data_mem_1 = '0;
    info_hilo_mem_1 = '0;
    info_cp0_mem_1  = '0;
    load_info_mem_1 = '0;
    pc_mempt1       = '0;
  endtask

  task automatic issue(input logic [4:0] waddr, input logic wen, input logic is_load,
                       input logic [2:0] ld_type, input logic [1:0] addr_lo,
                       input logic [31:0] wdata_in, input logic [31:0] exp_wdata,
                       input logic push, input int k);
    exp_t e;
    info_data_mem_1 = {wdata_in, waddr, wen, 1'b1};
    info_hilo_mem_1 = {2'b10, 32'h1111_0000 + k, 32'h2222_0000 + k, 2'b01};
    info_cp0_mem_1  = {32'h3333_0000 + k, 5'd12, 1'b1, 1'b1};
    load_info_mem_1 = {is_load, ld_type, addr_lo};
    pc_mempt1       = 32'hBFC0_0000 + 32'(k * 4);
    if (push) begin
      e.d  = {exp_wdata, waddr, wen, 1'b1};
      e.h  = {2'b10, 32'h1111_0000 + k, 32'h2222_0000 + k, 2'b01};
      e.c  = {32'h3333_0000 + k, 5'd12, 1'b1, 1'b1};
      e.pc = 32'hBFC0_0000 + 32'(k * 4);
      sb.push_back(e);
    end
  endtask

  // monitor: a valid payload is handed to WB whenever this stage is not held
  always @(negedge clk) begin
    if (!resetn && info_data_mem_2[0] && !stall[1]) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mon_unexpected: got %0h expected none", info_data_mem_2);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_data", 128'(info_data_mem_2), 128'(e.d));
        check("mon_hilo", 128'(info_hilo_mem_2), 128'(e.h));
        check("mon_cp0",  128'(info_cp0_mem_2),  128'(e.c));
        check("mon_pc",   128'(pc_mempt2),       128'(e.pc));
      end
    end
  end

  logic [2:0]  t2_type [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
  logic [1:0]  t2_addr [4] = '{2'd3, 2'd2, 2'd2, 2'd0};
  logic [31:0] t2_exp  [4] = '{32'hFFFF_FF80, 32'h0000_00AA, 32'hFFFF_80AA, 32'h0000_BB11};

  initial begin
    resetn      = 1'b1;
    flush       = 1'b0;
    stall_force = 2'b00;
    data_ok     = 1'b0;
    rdata       = '0;
    idle_inputs();
    tick();
    tick();
    check("rst_data", 128'(info_data_mem_2), 128'(0));
    check("rst_stall_req", 128'(stall_req), 128'(0));
    check("rst_cnt", 128'(ld_wait_cnt), 128'(0));
    @(negedge clk);
    resetn = 1'b0;
    tick();

    // 1: LW r5, response three cycles after latch
    issue(5'd5, 1'b1, 1'b1, 3'd4, 2'd0, 32'h0, 32'h8000_00F0, 1'b1, 1);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_stall_req_hi", 128'(stall_req), 128'(1));
      check("t1_fwd_pending", 128'(fwd_pending), 128'(1));
      tick();
    end
    data_ok = 1'b1;
    rdata   = 32'h8000_00F0;
    @(negedge clk);
    check("t1_stall_req_lo", 128'(stall_req), 128'(0));
    check("t1_wait_cnt", 128'(ld_wait_cnt), 128'(3));
    tick();
    data_ok = 1'b0;
    tick();

    // 2: byte/halfword alignment and extension
    for (int i = 0; i < 4; i++) begin
      issue(5'(10 + i), 1'b1, 1'b1, t2_type[i], t2_addr[i], 32'h0, t2_exp[i], 1'b1, 2 + i);
      tick();
      idle_inputs();
      data_ok = 1'b1;
      rdata   = 32'h80AA_BB11;
      @(negedge clk);
      check("t2_wait_cnt", 128'(ld_wait_cnt), 128'(0));
      tick();
      data_ok = 1'b0;
    end
    tick();

    // 3: response while fully stalled, buffered until release
    issue(5'd9, 1'b1, 1'b1, 3'd4, 2'd0, 32'h0, 32'h1234_5678, 1'b1, 7);
    tick();
    idle_inputs();
    stall_force = 2'b11;
    tick();
    data_ok = 1'b1;
    rdata   = 32'h1234_5678;
    @(negedge clk);
    check("t3_comb_wdata", 128'(info_data_mem_2[38:7]), 128'(32'h1234_5678));
    tick();
    data_ok = 1'b0;
    rdata   = 32'hFFFF_0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t3_buf_wdata", 128'(info_data_mem_2[38:7]), 128'(32'h1234_5678));
      check("t3_buf_stall_req", 128'(stall_req), 128'(0));
      tick();
    end
    stall_force = 2'b00;
    tick();
    tick();

    // 4: flush while waiting, late response is swallowed
    issue(5'd6, 1'b1, 1'b1, 3'd4, 2'd0, 32'h0, 32'h0, 1'b0, 8);
    tick();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("t4_payload_clr", 128'(info_data_mem_2), 128'(0));
    check("t4_drain_stall", 128'(stall_req), 128'(1));
    tick();
    @(negedge clk);
    check("t4_drain_stall2", 128'(stall_req), 128'(1));
    tick();
    data_ok = 1'b1;
    rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t4_fwd_en", 128'(fwd_en), 128'(0));
    check("t4_fwd_data", 128'(fwd_data), 128'(0));
    check("t4_payload_ok", 128'(info_data_mem_2), 128'(0));
    tick();
    data_ok = 1'b0;
    @(negedge clk);
    check("t4_idle_stall", 128'(stall_req), 128'(0));
    tick();

    // 5: bubble insertion, then single-cycle pass-through of an ALU result
    stall_force = 2'b10;
    issue(5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 32'hCAFE_0007, 32'h0, 1'b0, 9);
    tick();
    @(negedge clk);
    check("t5_bubble", 128'(info_data_mem_2), 128'(0));
    tick();
    stall_force = 2'b00;
    issue(5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 32'hCAFE_0007, 32'hCAFE_0007, 1'b1, 9);
    tick();
    idle_inputs();
    @(negedge clk);
    check("t5_fwd_en", 128'(fwd_en), 128'(1));
    check("t5_fwd_addr", 128'(fwd_addr), 128'(7));
    check("t5_fwd_data", 128'(fwd_data), 128'(32'hCAFE_0007));
    tick();

    // 6: asynchronous reset in the middle of a wait
    issue(5'd3, 1'b1, 1'b1, 3'd4, 2'd0, 32'h0, 32'h0, 1'b0, 10);
    tick();
    idle_inputs();
    check("t6_pre_stall", 128'(stall_req), 128'(1));
    #2;
    resetn = 1'b1;
    #1;
    check("t6_rst_data", 128'(info_data_mem_2), 128'(0));
    check("t6_rst_pc", 128'(pc_mempt2), 128'(0));
    check("t6_rst_stall", 128'(stall_req), 128'(0));
    check("t6_rst_cnt", 128'(ld_wait_cnt), 128'(0));
    @(negedge clk);
    resetn = 1'b0;
    tick();
    data_ok = 1'b1;
    rdata   = 32'h5555_AAAA;
    @(negedge clk);
    check("t6_idle_dok_stall", 128'(stall_req), 128'(0));
    check("t6_idle_dok_data", 128'(info_data_mem_2), 128'(0));
    tick();
    data_ok = 1'b0;
    @(negedge clk);
    check("t6_after_data", 128'(info_data_mem_2), 128'(0));
    check("t6_after_cnt", 128'(ld_wait_cnt), 128'(0));
    tick();

    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
